// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port unified memory between the instruction
// fetch port (IM) and the data port (DM). Each access has a fixed latency.
// stall is held high until every pending request has completed.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no access in flight; picks DM first, then IM
//   IM_WAIT | fetch issued; counting down to capture into im_data
//   DM_WAIT | data read/write issued; counting down to completion
module mem_arbiter #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter logic [1:0]  IM_REGION   = 2'b11
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        im_req,
  input  logic [9:0]  im_address,
  output logic [31:0] im_data,
  output logic        im_valid,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [11:0] dm_address,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        stall,
  output logic        mem_enable,
  output logic        mem_read,
  output logic        mem_write,
  output logic [11:0] mem_address,
  output logic [31:0] mem_in,
  input  logic [31:0] mem_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IM_WAIT = 2'd1,
    DM_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] LATENCY = 4'(MEM_LATENCY);

  state_t      state, state_nxt;
  logic [3:0]  count, count_nxt;
  logic        im_done, im_done_nxt;
  logic        dm_done, dm_done_nxt;
  logic [31:0] im_data_nxt, dm_rdata_nxt;
  logic        mem_enable_nxt, mem_read_nxt, mem_write_nxt;
  logic [11:0] mem_address_nxt;
  logic [31:0] mem_in_nxt;
  logic        im_pend, dm_pend;

  // A request is pending until its done flag is set; the flag keeps a held
  // request from being reissued while the other port is still being served.
  always_comb begin
    im_pend = im_req & ~im_done;
    dm_pend = (dm_read | dm_write) & ~dm_done;
    stall   = im_pend | dm_pend;
  end

  assign im_valid = im_done;
  assign dm_valid = dm_done;

  // State, counter, flags and all memory-side outputs are registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= 4'd0;
      im_done     <= 1'b0;
      dm_done     <= 1'b0;
      im_data     <= 32'd0;
      dm_rdata    <= 32'd0;
      mem_enable  <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= 12'd0;
      mem_in      <= 32'd0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      im_done     <= im_done_nxt;
      dm_done     <= dm_done_nxt;
      im_data     <= im_data_nxt;
      dm_rdata    <= dm_rdata_nxt;
      mem_enable  <= mem_enable_nxt;
      mem_read    <= mem_read_nxt;
      mem_write   <= mem_write_nxt;
      mem_address <= mem_address_nxt;
      mem_in      <= mem_in_nxt;
    end
  end

  // Next-state and registered-output logic; everything holds by default.
  always_comb begin
    state_nxt       = state;
    count_nxt       = count;
    im_done_nxt     = im_done;
    dm_done_nxt     = dm_done;
    im_data_nxt     = im_data;
    dm_rdata_nxt    = dm_rdata;
    mem_enable_nxt  = mem_enable;
    mem_read_nxt    = mem_read;
    mem_write_nxt   = mem_write;
    mem_address_nxt = mem_address;
    mem_in_nxt      = mem_in;

    // Pipeline advances on any unstalled edge, retiring both done flags.
    if (!stall) begin
      im_done_nxt = 1'b0;
      dm_done_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        // DM belongs to the older instruction, so it wins a tie.
        if (dm_pend) begin
          state_nxt       = DM_WAIT;
          count_nxt       = LATENCY;
          mem_enable_nxt  = 1'b1;
          mem_read_nxt    = dm_read;
          // Read and write together is illegal; it degrades to a read.
          mem_write_nxt   = dm_write & ~dm_read;
          mem_address_nxt = dm_address;
          mem_in_nxt      = dm_wdata;
        end else if (im_pend) begin
          state_nxt       = IM_WAIT;
          count_nxt       = LATENCY;
          mem_enable_nxt  = 1'b1;
          mem_read_nxt    = 1'b1;
          mem_write_nxt   = 1'b0;
          mem_address_nxt = {IM_REGION, im_address};
          mem_in_nxt      = 32'd0;
        end
      end
      IM_WAIT: begin
        count_nxt = count - 4'd1;
        if (count == 4'd1) begin
          state_nxt       = IDLE;
          im_data_nxt     = mem_out;
          im_done_nxt     = 1'b1;
          mem_enable_nxt  = 1'b0;
          mem_read_nxt    = 1'b0;
          mem_write_nxt   = 1'b0;
          mem_address_nxt = 12'd0;
          mem_in_nxt      = 32'd0;
        end
      end
      DM_WAIT: begin
        count_nxt = count - 4'd1;
        if (count == 4'd1) begin
          state_nxt = IDLE;
          if (mem_read) dm_rdata_nxt = mem_out;
          dm_done_nxt     = 1'b1;
          mem_enable_nxt  = 1'b0;
          mem_read_nxt    = 1'b0;
          mem_write_nxt   = 1'b0;
          mem_address_nxt = 12'd0;
          mem_in_nxt      = 32'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one instance at latency 1 driven from a vector
// table, one at latency 3 for the multi-cycle write/read-back sequence.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  // latency-1 instance
  logic        reset1, im_req1, im_valid1, dm_read1, dm_write1, dm_valid1, stall1;
  logic        mem_enable1, mem_read1, mem_write1;
  logic [9:0]  im_address1;
  logic [11:0] dm_address1, mem_address1;
  logic [31:0] im_data1, dm_wdata1, dm_rdata1, mem_in1, mem_out1;
  logic [31:0] mem1 [0:4095];

  // latency-3 instance
  logic        reset3, im_req3, im_valid3, dm_read3, dm_write3, dm_valid3, stall3;
  logic        mem_enable3, mem_read3, mem_write3;
  logic [9:0]  im_address3;
  logic [11:0] dm_address3, mem_address3;
  logic [31:0] im_data3, dm_wdata3, dm_rdata3, mem_in3, mem_out3;
  logic [31:0] mem3 [0:4095];

  mem_arbiter #(.MEM_LATENCY(1), .IM_REGION(2'b11)) dut1 (
    .clock(clock), .reset(reset1),
    .im_req(im_req1), .im_address(im_address1), .im_data(im_data1), .im_valid(im_valid1),
    .dm_read(dm_read1), .dm_write(dm_write1), .dm_address(dm_address1), .dm_wdata(dm_wdata1),
    .dm_rdata(dm_rdata1), .dm_valid(dm_valid1), .stall(stall1),
    .mem_enable(mem_enable1), .mem_read(mem_read1), .mem_write(mem_write1),
    .mem_address(mem_address1), .mem_in(mem_in1), .mem_out(mem_out1));

  mem_arbiter #(.MEM_LATENCY(3), .IM_REGION(2'b11)) dut3 (
    .clock(clock), .reset(reset3),
    .im_req(im_req3), .im_address(im_address3), .im_data(im_data3), .im_valid(im_valid3),
    .dm_read(dm_read3), .dm_write(dm_write3), .dm_address(dm_address3), .dm_wdata(dm_wdata3),
    .dm_rdata(dm_rdata3), .dm_valid(dm_valid3), .stall(stall3),
    .mem_enable(mem_enable3), .mem_read(mem_read3), .mem_write(mem_write3),
    .mem_address(mem_address3), .mem_in(mem_in3), .mem_out(mem_out3));

  // memory models: word i preloads to 5A00_0000|i, writes commit on the edge
  assign mem_out1 = mem1[mem_address1];
  assign mem_out3 = mem3[mem_address3];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem1[i] = 32'h5A00_0000 | 32'(i);
      mem3[i] = 32'h5A00_0000 | 32'(i);
    end
    mem1[12'hC05] = 32'h1234_5678;
    mem1[12'h010] = 32'hDEAD_BEEF;
    forever begin
      @(posedge clock);
      if (mem_enable1 && mem_write1) mem1[mem_address1] = mem_in1;
      if (mem_enable3 && mem_write3) mem3[mem_address3] = mem_in3;
    end
  end

  // read and write together is illegal stimulus
  always @(negedge clock) begin
    assert (!(dm_read1 && dm_write1) && !(dm_read3 && dm_write3))
      else $error("illegal dm_read and dm_write together");
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        im_req;
    logic [9:0]  im_addr;
    logic        dm_rd;
    logic        dm_wr;
    logic [11:0] dm_addr;
    logic [31:0] wdata;
    int          exp_stall;
    int          exp_issues;
    logic [11:0] exp_last;
    logic [31:0] exp_im_data;
    logic [31:0] exp_dm_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ir, logic [9:0] ia, logic rd, logic wr, logic [11:0] da,
                              logic [31:0] wd, int st, int is, logic [11:0] la,
                              logic [31:0] eim, logic [31:0] edm);
    vec_t v;
    v.im_req = ir; v.im_addr = ia; v.dm_rd = rd; v.dm_wr = wr; v.dm_addr = da; v.wdata = wd;
    v.exp_stall = st; v.exp_issues = is; v.exp_last = la;
    v.exp_im_data = eim; v.exp_dm_rdata = edm;
    return v;
  endfunction

  // Waits (bounded) for stall1 to drop, counting stalled cycles and memory
  // accesses, and flagging back-to-back enables at different addresses.
  task automatic wait1(output int cyc, output int iss, output logic [11:0] last, output int ovl);
    logic        pe;
    logic [11:0] pa;
    cyc = 0; iss = 0; last = 12'd0; ovl = 0; pe = 1'b0; pa = 12'd0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clock);
      if (mem_enable1 && !pe) begin iss++; last = mem_address1; end
      if (mem_enable1 && pe && mem_address1 != pa) ovl++;
      pe = mem_enable1; pa = mem_address1;
      if (!stall1) break;
      cyc++;
    end
  endtask

  int          cyc, iss, ovl, wr_cyc, in_bad;
  logic [11:0] last;

  initial begin
    reset1 = 1'b1; im_req1 = 0; im_address1 = 0; dm_read1 = 0; dm_write1 = 0;
    dm_address1 = 0; dm_wdata1 = 0;
    reset3 = 1'b1; im_req3 = 0; im_address3 = 0; dm_read3 = 0; dm_write3 = 0;
    dm_address3 = 0; dm_wdata3 = 0;

    vecs.push_back(mk(1, 10'h005, 0, 0, 12'h000, 32'h0,         2, 1, 12'hC05, 32'h1234_5678, 32'h0));
    vecs.push_back(mk(1, 10'h001, 1, 0, 12'h010, 32'h0,         4, 2, 12'hC01, 32'h5A00_0C01, 32'hDEAD_BEEF));
    vecs.push_back(mk(0, 10'h000, 0, 1, 12'h030, 32'hCAFE_0030, 2, 1, 12'h030, 32'h5A00_0C01, 32'hDEAD_BEEF));
    vecs.push_back(mk(0, 10'h000, 1, 0, 12'h030, 32'h0,         2, 1, 12'h030, 32'h5A00_0C01, 32'hCAFE_0030));
    vecs.push_back(mk(1, 10'h3FF, 0, 1, 12'h040, 32'h1111_2222, 4, 2, 12'hFFF, 32'h5A00_0FFF, 32'hCAFE_0030));
    vecs.push_back(mk(0, 10'h000, 1, 0, 12'h040, 32'h0,         2, 1, 12'h040, 32'h5A00_0FFF, 32'h1111_2222));
    vecs.push_back(mk(0, 10'h000, 0, 0, 12'h000, 32'h0,         0, 0, 12'h000, 32'h5A00_0FFF, 32'h1111_2222));
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(1, 10'h100 + 10'(k), 0, 0, 12'h000, 32'h0, 2, 1, 12'hD00 + 12'(k),
                        32'h5A00_0D00 + 32'(k), 32'h1111_2222));

    #1;
    chk("reset im_data", im_data1, 32'h0);
    chk("reset dm_rdata", dm_rdata1, 32'h0);
    chk("reset mem_enable", {31'd0, mem_enable1}, 32'h0);
    chk("reset mem_address", {20'd0, mem_address1}, 32'h0);
    chk("reset stall", {31'd0, stall1}, 32'h0);
    chk("reset valids", {30'd0, im_valid1, dm_valid1}, 32'h0);
    repeat (2) @(negedge clock);
    reset1 = 1'b0; reset3 = 1'b0;
    @(posedge clock); #1;

    for (int v = 0; v < vecs.size(); v++) begin
      im_req1 = vecs[v].im_req; im_address1 = vecs[v].im_addr;
      dm_read1 = vecs[v].dm_rd; dm_write1 = vecs[v].dm_wr;
      dm_address1 = vecs[v].dm_addr; dm_wdata1 = vecs[v].wdata;
      wait1(cyc, iss, last, ovl);
      chk($sformatf("v%0d stall cycles", v), 32'(cyc), 32'(vecs[v].exp_stall));
      chk($sformatf("v%0d accesses", v), 32'(iss), 32'(vecs[v].exp_issues));
      chk($sformatf("v%0d enable overlap", v), 32'(ovl), 32'd0);
      if (iss > 0) chk($sformatf("v%0d last address", v), {20'd0, last}, {20'd0, vecs[v].exp_last});
      chk($sformatf("v%0d im_valid", v), {31'd0, im_valid1}, {31'd0, vecs[v].im_req});
      chk($sformatf("v%0d dm_valid", v), {31'd0, dm_valid1}, {31'd0, vecs[v].dm_rd | vecs[v].dm_wr});
      chk($sformatf("v%0d im_data", v), im_data1, vecs[v].exp_im_data);
      chk($sformatf("v%0d dm_rdata", v), dm_rdata1, vecs[v].exp_dm_rdata);
      @(posedge clock); #1;
      chk($sformatf("v%0d done cleared", v), {30'd0, im_valid1, dm_valid1}, 32'h0);
    end
    im_req1 = 0; dm_read1 = 0; dm_write1 = 0;

    // reset in the middle of a data read, then reissue after release
    dm_read1 = 1; dm_address1 = 12'h050;
    @(posedge clock);
    @(negedge clock);
    chk("midreset enable before", {31'd0, mem_enable1}, 32'h1);
    reset1 = 1'b1;
    #1;
    chk("midreset mem controls", {29'd0, mem_enable1, mem_read1, mem_write1}, 32'h0);
    chk("midreset mem_address", {20'd0, mem_address1}, 32'h0);
    chk("midreset dm_valid", {31'd0, dm_valid1}, 32'h0);
    chk("midreset dm_rdata", dm_rdata1, 32'h0);
    chk("midreset stall", {31'd0, stall1}, 32'h1);
    @(posedge clock);
    @(negedge clock);
    reset1 = 1'b0;
    wait1(cyc, iss, last, ovl);
    chk("reissue stall cycles", 32'(cyc), 32'd1);
    chk("reissue accesses", 32'(iss), 32'd1);
    chk("reissue address", {20'd0, last}, 32'h050);
    chk("reissue dm_valid", {31'd0, dm_valid1}, 32'h1);
    chk("reissue dm_rdata", dm_rdata1, 32'h5A00_0050);
    @(posedge clock); #1;
    dm_read1 = 0;

    // latency 3: write, then read it back
    dm_write3 = 1; dm_address3 = 12'h020; dm_wdata3 = 32'hA5A5_0001;
    cyc = 0; wr_cyc = 0; in_bad = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clock);
      if (mem_write3) begin
        wr_cyc++;
        if (mem_in3 !== 32'hA5A5_0001 || mem_address3 !== 12'h020) in_bad++;
      end
      if (!stall3) break;
      cyc++;
    end
    chk("lat3 write stall cycles", 32'(cyc), 32'd4);
    chk("lat3 mem_write cycles", 32'(wr_cyc), 32'd3);
    chk("lat3 mem_in stable", 32'(in_bad), 32'd0);
    chk("lat3 write dm_valid", {31'd0, dm_valid3}, 32'h1);
    chk("lat3 write dm_rdata", dm_rdata3, 32'h0);
    @(posedge clock); #1;
    dm_write3 = 0; dm_read3 = 1; dm_wdata3 = 32'h0;
    cyc = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clock);
      if (!stall3) break;
      cyc++;
    end
    chk("lat3 read stall cycles", 32'(cyc), 32'd4);
    chk("lat3 read dm_rdata", dm_rdata3, 32'hA5A5_0001);
    @(posedge clock); #1;
    dm_read3 = 0;
    chk("lat3 done cleared", {31'd0, dm_valid3}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port unified memory between the pipeline's instruction-fetch port (IM) and the memory-access stage's data port (DM). It serialises the two requesters with a fixed-latency FSM and raises `stall` to freeze the PC and all pipeline register walls until every pending request has completed. It sits between the CPU core's IM_*/DM_* ports and the external memory macro, replacing the separate IM/DM connections.

## Interface
- `MEM_LATENCY`, default 1: cycles from issue to `mem_out` valid; legal range 1–15.
- `IM_REGION`, default 2'b11: upper two memory address bits for instruction words.
- `clock` in 1: rising-edge clock.
- `reset` in 1: one clock; reset is asynchronous and active-high.
- `im_req` in 1: fetch request; held high with a stable address while `stall`=1.
- `im_address` in 10: instruction word address.
- `im_data` out 32: last fetched instruction; holds its value between fetches.
- `im_valid` out 1: the fetch for the current cycle has completed.
- `dm_read` in 1: data read request.
- `dm_write` in 1: data write request; mutually exclusive with `dm_read`.
- `dm_address` in 12: data word address.
- `dm_wdata` in 32: write data.
- `dm_rdata` out 32: last read data; holds its value.
- `dm_valid` out 1: the DM access has completed.
- `stall` out 1: freezes PC and REG1–REG4 while high.
- `mem_enable`, `mem_read`, `mem_write` out 1 each: memory controls.
- `mem_address` out 12: memory address.
- `mem_in` out 32: memory write data.
- `mem_out` in 32: memory read data.

## Operation
- FSM states: IDLE, IM_WAIT, DM_WAIT. Registers: 4-bit `count`; flags `im_done` and `dm_done`; data registers `im_data` and `dm_rdata`.
- Pending requests: `im_pend = im_req & ~im_done`; `dm_pend = (dm_read | dm_write) & ~dm_done`.
- `stall = im_pend | dm_pend`. This is combinational.
- IDLE transitions, evaluated at the clock edge:
  - If `dm_pend`: go to DM_WAIT and load `count = MEM_LATENCY`.
  - Otherwise, if `im_pend`: go to IM_WAIT and load `count = MEM_LATENCY`.
  - DM has fixed priority because it belongs to the older instruction.
- Signals registered on entry to IM_WAIT:
  - `mem_enable=1`, `mem_read=1`, `mem_write=0`.
  - `mem_address = {IM_REGION, im_address}`.
- Signals registered on entry to DM_WAIT:
  - `mem_enable=1`, `mem_read=dm_read`, `mem_write=dm_write`.
  - `mem_address = dm_address`, `mem_in = dm_wdata`.
- In a WAIT state, memory outputs hold and `count` decrements at each edge.
- At the edge where `count==1`:
  - Return to IDLE and clear all `mem_*` outputs to 0.
  - IM_WAIT: capture `mem_out` into `im_data` and set `im_done`.
  - DM_WAIT: set `dm_done`, and capture `mem_out` into `dm_rdata` only if the access was a read.
- `im_valid = im_done` and `dm_valid = dm_done`.
- At any edge where `stall==0`, the pipeline advances and both done flags clear.
- Requests that deassert while their done flag is set cause no new access.
- Address widths: IM is zero-extended into the `IM_REGION` window. DM addresses are passed through unchanged. No overlap check is done; software must keep data out of the IM window.

## Timing
- Reset (async, while `reset`=1):
  - State IDLE, `count=0`, both done flags 0.
  - `im_data`=0, `dm_rdata`=0.
  - All `mem_*` outputs 0.
  - `stall` follows its inputs combinationally; with no requests it is 0.
- A reset in the middle of an access abandons that access. After reset release, still-asserted requests are reissued from IDLE.
- Single request: issue at edge 1, data captured at edge 1+`MEM_LATENCY`. `stall` is high for `MEM_LATENCY`+1 cycles.
- Simultaneous IM and DM requests: the DM access runs first, then one IDLE cycle, then the IM access. `stall` is high for 2×(`MEM_LATENCY`+1) cycles.
- `mem_enable` is never high for two different accesses without an intervening low cycle.
- Both `dm_read` and `dm_write` high is illegal. The bench asserts on it; the RTL treats it as a read.

## Test plan
- Reset mid-access:
  - Stimulus: assert `reset` during DM_WAIT.
  - Response: `mem_*`=0, `dm_valid`=0 and `dm_rdata`=0 immediately.
  - After release, the still-pending read reissues and completes normally.
- IM-only fetch, `MEM_LATENCY`=1, `im_address`=10'h005, memory word 0xC05=32'h1234_5678:
  - `mem_address`=12'hC05 for 1 cycle.
  - `stall` high for 2 cycles.
  - `im_data`=32'h1234_5678 with `im_valid`=1 in cycle 2.
- Simultaneous fetch and read, `MEM_LATENCY`=1, `im_address`=10'h001, `dm_read` at 12'h010 (word = 32'hDEAD_BEEF):
  - DM issues first.
  - `dm_rdata`=32'hDEAD_BEEF after cycle 2.
  - IM issues at edge 3.
  - `stall` high for exactly 4 cycles.
- DM write, `MEM_LATENCY`=3, `dm_address`=12'h020, `dm_wdata`=32'hA5A5_0001:
  - `mem_write`=1 and `mem_in` stable for 3 cycles.
  - `dm_rdata` unchanged.
  - Stall lasts 4 cycles.
  - A later read of 12'h020 returns 32'hA5A5_0001.
- Back-to-back fetches, 8 consecutive `im_address` values, no DM traffic:
  - Each fetch stalls 2 cycles.
  - The done flag clears on every advance.
  - No address is fetched twice.
